instr_fetch_unit: RTL

- Instruction-supply stage directly upstream of the single-cycle RISC-V core.
- Takes the core's current PC and returns the 32-bit Instruction word from a one-line fetch buffer.
- On a buffer miss, fills the whole line from instruction memory over a req/ack handshake, and asserts Stall until the word is available.
- Hides variable memory latency; sequential hits within a line need no memory traffic.

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one-line fetch buffer in front of instruction memory.
// Define IFU_PERF_CNT_EN to add saturating hit_count / miss_count outputs.
module instr_fetch_unit #(
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic        Stall,
  output logic        Misaligned,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW  = $clog2(LINE_WORDS);
  localparam int OFS = IW + 2;
  localparam int TW  = 32 - OFS;
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state, state_nx;

  logic [31:0]   lbuf [LINE_WORDS];
  logic [TW-1:0] lbuf_tag;
  logic [TW-1:0] fill_tag;
  logic [TW-1:0] tag;
  logic          lbuf_valid;
  logic [IW-1:0] fill_cnt;
  logic [IW-1:0] idx;
  logic          hit;
  logic          start_fill;
  logic          take_ack;
  logic          last_ack;

  assign tag        = PC[31:OFS];
  assign idx        = PC[OFS-1:2];
  assign Misaligned = |PC[1:0];

  // A hit is only trusted while no fill is rewriting the line.
  assign hit = lbuf_valid && (lbuf_tag == tag)
            && !Misaligned && (state == IDLE);

  assign Instruction = hit ? lbuf[idx] : NOP_INSTR;
  assign InstrValid  = hit;
  assign Stall       = !hit && !Misaligned;

  // Next-state: start a fill on an aligned miss, finish on the last ack.
  always_comb begin
    state_nx   = state;
    start_fill = 1'b0;
    take_ack   = 1'b0;
    last_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!hit && !Misaligned) begin
          state_nx   = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        if (imem_ack) begin
          take_ack = 1'b1;
          if (fill_cnt == LAST) begin
            last_ack = 1'b1;
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  // State, tags and the registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lbuf_valid <= 1'b0;
      lbuf_tag   <= '0;
      fill_tag   <= '0;
      fill_cnt   <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
    end else begin
      state <= state_nx;
      if (start_fill) begin
        fill_tag   <= tag;
        fill_cnt   <= '0;
        lbuf_valid <= 1'b0;
        imem_req   <= 1'b1;
        imem_addr  <= {tag, {OFS{1'b0}}};
      end
      if (take_ack) begin
        fill_cnt  <= fill_cnt + 1'b1;
        imem_addr <= imem_addr + 32'd4;
      end
      if (last_ack) begin
        imem_req   <= 1'b0;
        lbuf_tag   <= fill_tag;
        lbuf_valid <= 1'b1;
      end
    end
  end

  // Line data needs no reset; lbuf_valid guards it.
  always_ff @(posedge clk) begin
    if (take_ack) begin
      lbuf[fill_cnt] <= imem_rdata;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating hit and miss counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (InstrValid && hit_count != '1) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_fill && miss_count != '1) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
